// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: ALU opcodes and sequencer phases.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR
    } op_t;

    typedef enum logic [1:0] {
        PH_OPERAND,
        PH_OPERATION,
        PH_COMPUTE,
        PH_RESULT
    } phase_t;

endpackage

// File: rtl/calc_alu.sv
// Two-input unsigned ALU; carry reports ADD carry-out or SUB borrow.
module calc_alu
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_t          op,
    output logic [W-1:0] y,
    output logic         carry
);

    logic [W:0] sum;
    logic [W:0] diff;

    // The extra top bit of the difference is set exactly when b > a.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD:  {carry, y} = sum;
            OP_SUB:  {carry, y} = diff;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects operands and an opcode, then folds the
// operands left-to-right through calc_alu, one operand per cycle.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter  int N_OPERANDS = 2,
    parameter  int W          = 16,
    localparam int SW         = $clog2(N_OPERANDS + 3),
    localparam int CW         = $clog2(N_OPERANDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          trigger,
    input  logic          undo,
    input  logic [W-1:0]  operand_in,
    input  op_t           op_in,
    output logic [SW-1:0] step,
    output logic          busy,
    output logic [W-1:0]  result,
    output logic          result_valid,
    output logic          overflow
);

    localparam logic [CW-1:0] LAST = CW'(N_OPERANDS - 1);

    phase_t         phase_q, phase_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   opnd_q [N_OPERANDS];
    logic [W-1:0]   opnd_d [N_OPERANDS];
    op_t            opcode_q, opcode_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           ovf_q, ovf_d;
    logic [SW-1:0]  step_q, step_d;
    logic [W-1:0]   alu_y;
    logic           alu_carry;
    logic           adv;
    logic           back;

    // Simultaneous trigger and undo cancel each other out.
    assign adv  = trigger & ~undo;
    assign back = undo & ~trigger;

    calc_alu #(.W(W)) u_alu (
        .a     (acc_q),
        .b     (opnd_q[cnt_q]),
        .op    (opcode_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_comb begin
        phase_d  = phase_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        opcode_d = opcode_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        step_d   = step_q;

        case (phase_q)
            PH_OPERAND: begin
                if (adv) begin
                    opnd_d[idx_q] = operand_in;
                    if (idx_q == LAST) phase_d = PH_OPERATION;
                    else               idx_d   = idx_q + 1'b1;
                end else if (back && idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end
            end
            PH_OPERATION: begin
                if (adv) begin
                    opcode_d = op_in;
                    acc_d    = opnd_q[0];
                    cnt_d    = CW'(1);
                    ovf_d    = 1'b0;
                    phase_d  = PH_COMPUTE;
                end else if (back) begin
                    idx_d   = LAST;
                    phase_d = PH_OPERAND;
                end
            end
            PH_COMPUTE: begin
                acc_d = alu_y;
                ovf_d = ovf_q | alu_carry;
                // cnt parks on the last operand so it never indexes past the array.
                if (cnt_q == LAST) phase_d = PH_RESULT;
                else               cnt_d   = cnt_q + 1'b1;
            end
            PH_RESULT: begin
                if (adv) begin
                    idx_d   = '0;
                    phase_d = PH_OPERAND;
                end else if (back) begin
                    phase_d = PH_OPERATION;
                end
            end
            default: phase_d = PH_OPERAND;
        endcase

        case (phase_d)
            PH_OPERAND:   step_d = SW'(idx_d);
            PH_OPERATION: step_d = SW'(N_OPERANDS);
            PH_COMPUTE:   step_d = SW'(N_OPERANDS + 1);
            PH_RESULT:    step_d = SW'(N_OPERANDS + 2);
            default:      step_d = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_OPERAND;
            idx_q    <= '0;
            cnt_q    <= '0;
            opcode_q <= OP_ADD;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            step_q   <= '0;
            for (int i = 0; i < N_OPERANDS; i++) opnd_q[i] <= '0;
        end else begin
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            step_q   <= step_d;
            for (int i = 0; i < N_OPERANDS; i++) opnd_q[i] <= opnd_d[i];
        end
    end

    assign step         = step_q;
    assign busy         = (phase_q == PH_COMPUTE);
    assign result       = acc_q;
    assign result_valid = (phase_q == PH_RESULT);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed scoreboard bench for calc_sequencer at N=2/W=16 and N=4/W=8.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst2, trig2, undo2, busy2, valid2, ovf2;
    logic [15:0] opnd2, res2;
    op_t         op2;
    logic [2:0]  step2;

    logic        rst4, trig4, undo4, busy4, valid4, ovf4;
    logic [7:0]  opnd4, res4;
    op_t         op4;
    logic [2:0]  step4;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp2_q [$];
    logic [8:0]  exp4_q [$];

    calc_sequencer #(.N_OPERANDS(2), .W(16)) dut2 (
        .clock(clock), .reset(rst2), .trigger(trig2), .undo(undo2),
        .operand_in(opnd2), .op_in(op2), .step(step2), .busy(busy2),
        .result(res2), .result_valid(valid2), .overflow(ovf2)
    );

    calc_sequencer #(.N_OPERANDS(4), .W(8)) dut4 (
        .clock(clock), .reset(rst4), .trigger(trig4), .undo(undo4),
        .operand_in(opnd4), .op_in(op4), .step(step4), .busy(busy4),
        .result(res4), .result_valid(valid4), .overflow(ovf4)
    );

    // Reference fold: plain integer arithmetic, masked to w bits after each step.
    function automatic logic [16:0] fold_model(input int n, input int w, input op_t op,
                                               input int v0, input int v1, input int v2, input int v3);
        longint vals [4];
        longint acc;
        longint mask;
        logic   ovf;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        mask = (longint'(1) << w) - 1;
        acc  = vals[0];
        ovf  = 1'b0;
        for (int k = 1; k < n; k++) begin
            case (op)
                OP_ADD: begin
                    acc = acc + vals[k];
                    if (acc > mask) ovf = 1'b1;
                    acc = acc & mask;
                end
                OP_SUB: begin
                    if (acc < vals[k]) ovf = 1'b1;
                    acc = (acc - vals[k]) & mask;
                end
                OP_AND:  acc = acc & vals[k];
                default: acc = acc | vals[k];
            endcase
        end
        return {ovf, acc[15:0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus2(input bit t, input bit u, input logic [15:0] v, input op_t o);
        @(negedge clock);
        trig2 = t; undo2 = u; opnd2 = v; op2 = o;
        @(negedge clock);
        trig2 = 1'b0; undo2 = 1'b0;
    endtask

    task automatic apply_stimulus4(input bit t, input bit u, input logic [7:0] v, input op_t o);
        @(negedge clock);
        trig4 = t; undo4 = u; opnd4 = v; op4 = o;
        @(negedge clock);
        trig4 = 1'b0; undo4 = 1'b0;
    endtask

    task automatic pop_compare2(input string tag);
        logic [16:0] e;
        if (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            check_output({tag, "_result"}, 32'(res2), 32'(e[15:0]));
            check_output({tag, "_overflow"}, 32'(ovf2), 32'(e[16]));
        end else begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end
    endtask

    task automatic pop_compare4(input string tag);
        logic [8:0] e;
        if (exp4_q.size() > 0) begin
            e = exp4_q.pop_front();
            check_output({tag, "_result"}, 32'(res4), 32'(e[7:0]));
            check_output({tag, "_overflow"}, 32'(ovf4), 32'(e[8]));
        end else begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end
    endtask

    // Called at the negedge right after the op trigger was sampled.
    task automatic wait_result2(input string tag);
        int cyc = 0;
        while (valid2 !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check_output({tag, "_latency"}, 32'(cyc + 1), 32'd2);
        check_output({tag, "_step"}, 32'(step2), 32'd4);
        pop_compare2(tag);
    endtask

    task automatic wait_result4(input string tag);
        int cyc = 0;
        int busy_cnt = 0;
        while (valid4 !== 1'b1 && cyc < 20) begin
            if (busy4 === 1'b1) busy_cnt++;
            @(negedge clock);
            cyc++;
        end
        check_output({tag, "_latency"}, 32'(cyc + 1), 32'd4);
        check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd3);
        check_output({tag, "_step"}, 32'(step4), 32'd6);
        pop_compare4(tag);
    endtask

    initial begin
        logic [16:0] m;
        rst2 = 1'b1; trig2 = 1'b0; undo2 = 1'b0; opnd2 = '0; op2 = OP_ADD;
        rst4 = 1'b1; trig4 = 1'b0; undo4 = 1'b0; opnd4 = '0; op4 = OP_ADD;
        #12;
        check_output("rst_step2", 32'(step2), 32'd0);
        check_output("rst_busy2", 32'(busy2), 32'd0);
        check_output("rst_valid2", 32'(valid2), 32'd0);
        check_output("rst_result2", 32'(res2), 32'd0);
        check_output("rst_step4", 32'(step4), 32'd0);
        check_output("rst_ovf4", 32'(ovf4), 32'd0);
        @(negedge clock);
        rst2 = 1'b0; rst4 = 1'b0;

        $display("[TB] basic add N=2");
        apply_stimulus2(1, 0, 16'd5, OP_ADD);
        check_output("t1_step_a", 32'(step2), 32'd1);
        apply_stimulus2(1, 0, 16'd7, OP_ADD);
        check_output("t1_step_op", 32'(step2), 32'd2);
        exp2_q.push_back(fold_model(2, 16, OP_ADD, 5, 7, 0, 0));
        apply_stimulus2(1, 0, 16'd0, OP_ADD);
        check_output("t1_busy", 32'(busy2), 32'd1);
        check_output("t1_step_compute", 32'(step2), 32'd3);
        wait_result2("t1");
        apply_stimulus2(1, 0, 16'd0, OP_ADD);
        check_output("t1_restart_step", 32'(step2), 32'd0);
        check_output("t1_restart_valid", 32'(valid2), 32'd0);

        $display("[TB] undo walk N=2");
        apply_stimulus2(0, 1, 16'd0, OP_ADD);
        check_output("t3_undo_at_0", 32'(step2), 32'd0);
        apply_stimulus2(1, 0, 16'd3, OP_ADD);
        apply_stimulus2(0, 1, 16'd0, OP_ADD);
        check_output("t3_undo_back", 32'(step2), 32'd0);
        apply_stimulus2(1, 0, 16'd9, OP_ADD);
        apply_stimulus2(1, 0, 16'd4, OP_ADD);
        exp2_q.push_back(fold_model(2, 16, OP_SUB, 9, 4, 0, 0));
        apply_stimulus2(1, 0, 16'd0, OP_SUB);
        wait_result2("t3");
        apply_stimulus2(1, 0, 16'd0, OP_ADD);

        $display("[TB] simultaneous pulses N=2");
        apply_stimulus2(1, 1, 16'hAAAA, OP_ADD);
        check_output("t4_both_op0", 32'(step2), 32'd0);
        apply_stimulus2(1, 0, 16'hFFFF, OP_ADD);
        apply_stimulus2(1, 1, 16'h5555, OP_ADD);
        check_output("t4_both_op1", 32'(step2), 32'd1);
        apply_stimulus2(1, 0, 16'h0002, OP_ADD);
        apply_stimulus2(1, 1, 16'h0000, OP_SUB);
        check_output("t4_both_operation", 32'(step2), 32'd2);
        exp2_q.push_back(fold_model(2, 16, OP_ADD, 'hFFFF, 'h0002, 0, 0));
        apply_stimulus2(1, 0, 16'h0000, OP_ADD);
        wait_result2("t4_wrap");
        apply_stimulus2(1, 1, 16'h0000, OP_ADD);
        check_output("t4_both_result_step", 32'(step2), 32'd4);
        check_output("t4_both_result_valid", 32'(valid2), 32'd1);

        $display("[TB] result undo and re-trigger N=2");
        apply_stimulus2(1, 0, 16'h0000, OP_ADD);
        apply_stimulus2(1, 0, 16'h000F, OP_ADD);
        apply_stimulus2(1, 0, 16'h00F0, OP_ADD);
        exp2_q.push_back(fold_model(2, 16, OP_SUB, 'h0F, 'hF0, 0, 0));
        apply_stimulus2(1, 0, 16'h0000, OP_SUB);
        wait_result2("t6_sub");
        apply_stimulus2(0, 1, 16'h0000, OP_ADD);
        check_output("t6_undo_step", 32'(step2), 32'd2);
        check_output("t6_undo_valid", 32'(valid2), 32'd0);
        exp2_q.push_back(fold_model(2, 16, OP_OR, 'h0F, 'hF0, 0, 0));
        apply_stimulus2(1, 0, 16'h0000, OP_OR);
        wait_result2("t6_or");
        apply_stimulus2(1, 0, 16'h0000, OP_ADD);
        check_output("t6_trigger_step", 32'(step2), 32'd0);

        $display("[TB] four-operand add with overflow");
        apply_stimulus4(1, 0, 8'd200, OP_ADD);
        apply_stimulus4(1, 0, 8'd50, OP_ADD);
        apply_stimulus4(1, 0, 8'd10, OP_ADD);
        apply_stimulus4(1, 0, 8'd1, OP_ADD);
        check_output("t2_step_op", 32'(step4), 32'd4);
        m = fold_model(4, 8, OP_ADD, 200, 50, 10, 1);
        exp4_q.push_back({m[16], m[7:0]});
        apply_stimulus4(1, 0, 8'd0, OP_ADD);
        wait_result4("t2");

        $display("[TB] pulses during compute");
        apply_stimulus4(1, 0, 8'd0, OP_ADD);
        apply_stimulus4(1, 0, 8'd10, OP_ADD);
        apply_stimulus4(1, 0, 8'd20, OP_ADD);
        apply_stimulus4(1, 0, 8'd3, OP_ADD);
        apply_stimulus4(1, 0, 8'd4, OP_ADD);
        m = fold_model(4, 8, OP_SUB, 10, 20, 3, 4);
        exp4_q.push_back({m[16], m[7:0]});
        apply_stimulus4(1, 0, 8'd0, OP_SUB);
        trig4 = 1'b1;
        @(negedge clock);
        trig4 = 1'b0; undo4 = 1'b1;
        @(negedge clock);
        trig4 = 1'b1;
        @(negedge clock);
        trig4 = 1'b0; undo4 = 1'b0;
        check_output("t4c_valid", 32'(valid4), 32'd1);
        check_output("t4c_step", 32'(step4), 32'd6);
        pop_compare4("t4c");

        $display("[TB] reset mid-compute");
        apply_stimulus4(1, 0, 8'd0, OP_ADD);
        apply_stimulus4(1, 0, 8'd1, OP_ADD);
        apply_stimulus4(1, 0, 8'd2, OP_ADD);
        apply_stimulus4(1, 0, 8'd3, OP_ADD);
        apply_stimulus4(1, 0, 8'd4, OP_ADD);
        apply_stimulus4(1, 0, 8'd0, OP_ADD);
        check_output("t5_busy_before", 32'(busy4), 32'd1);
        #2 rst4 = 1'b1;
        #1;
        check_output("t5_step", 32'(step4), 32'd0);
        check_output("t5_busy", 32'(busy4), 32'd0);
        check_output("t5_result", 32'(res4), 32'd0);
        check_output("t5_valid", 32'(valid4), 32'd0);
        @(negedge clock);
        rst4 = 1'b0;
        apply_stimulus4(1, 0, 8'd100, OP_ADD);
        apply_stimulus4(1, 0, 8'd100, OP_ADD);
        apply_stimulus4(1, 0, 8'd50, OP_ADD);
        apply_stimulus4(1, 0, 8'd5, OP_ADD);
        m = fold_model(4, 8, OP_ADD, 100, 100, 50, 5);
        exp4_q.push_back({m[16], m[7:0]});
        apply_stimulus4(1, 0, 8'd0, OP_ADD);
        wait_result4("t5_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
